// File: rtl/and_or_sweep_ctrl.sv
// Exhaustive 4-input sweep controller for an AND_OR datapath: drives all 16 vectors,
// checks each result and reports a pass/fail summary. Optional: AND_OR_SWEEP_STOP_ON_FAIL_EN.
module and_or_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] dut_in,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Counter counts down from SETTLE_CYCLES-1 to 0, giving exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [4:0] err_q, err_d;
  logic [3:0] ffv_q, ffv_d;
  logic       fail_q, fail_d;
  logic [3:0] settle_q, settle_d;

  logic       expected;
  logic       mismatch;
  logic       stop_sweep;

  assign expected = (vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]);
  assign mismatch = (dut_out != expected);

`ifdef AND_OR_SWEEP_STOP_ON_FAIL_EN
  assign stop_sweep = mismatch || (vec_q == 4'd15);
`else
  assign stop_sweep = (vec_q == 4'd15);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= 4'd0;
      err_q    <= 5'd0;
      ffv_q    <= 4'd0;
      fail_q   <= 1'b0;
      settle_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      fail_q   <= fail_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    fail_d   = fail_q;
    settle_d = settle_q;

    unique case (state_q)
      IDLE, DONE: begin
        // Abort outranks start, so a simultaneous abort swallows the request.
        if (start && !abort) begin
          state_d  = SETTLE;
          vec_d    = 4'd0;
          err_d    = 5'd0;
          ffv_d    = 4'd0;
          fail_d   = 1'b0;
          settle_d = SettleLoad;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_d  = IDLE;
          vec_d    = 4'd0;
          settle_d = 4'd0;
        end else if (settle_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      CHECK: begin
        if (abort) begin
          state_d  = IDLE;
          vec_d    = 4'd0;
          settle_d = 4'd0;
        end else begin
          if (mismatch) begin
            if (err_q != 5'd16) err_d = err_q + 5'd1;
            if (!fail_q) ffv_d = vec_q;
            fail_d = 1'b1;
          end
          if (stop_sweep) begin
            state_d = DONE;
          end else begin
            state_d  = SETTLE;
            vec_d    = vec_q + 4'd1;
            settle_d = SettleLoad;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SETTLE) || (state_q == CHECK);
    done = (state_q == DONE);
    pass = (state_q == DONE) && (err_q == 5'd0);
  end

  assign dut_in         = vec_q;
  assign err_cnt        = err_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_and_or_sweep_ctrl.sv
// Directed testbench for and_or_sweep_ctrl with a switchable model of the AND_OR datapath
// (correct, stuck-at-0, stuck-at-1). Honours AND_OR_SWEEP_STOP_ON_FAIL_EN.
module tb_and_or_sweep_ctrl;

  localparam int Settle = 2;
  localparam int Sweep  = 16 * (Settle + 1);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] dut_in;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic [3:0] first_fail_vec;

  logic [1:0] mode;
  int         vectors     = 0;
  int         miscompares = 0;
  int         cycles;

  and_or_sweep_ctrl #(.SETTLE_CYCLES(Settle)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .dut_in        (dut_in),
    .dut_out       (dut_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_fail_vec(first_fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: mode 0 is a good AND_OR, 1 is stuck at 0, 2 is stuck at 1.
  always_comb begin
    case (mode)
      2'd1:    dut_out = 1'b0;
      2'd2:    dut_out = 1'b1;
      default: dut_out = (dut_in[3] & dut_in[2]) | (dut_in[1] & dut_in[0]);
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
  endtask

  // Pulse start for one cycle; returns at the first negedge after the accept edge.
  task automatic pulseStart();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic runSweep(output int n);
    pulseStart();
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sweep_done", done, 1);
  endtask

  initial begin
    mode  = 2'd0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    #12;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_dut_in", dut_in, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    checkOutput("rst_ffv", first_fail_vec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_wait_busy", busy, 0);
    checkOutput("idle_wait_done", done, 0);

    // Good datapath: full sweep, done exactly 48 cycles after accept.
    mode = 2'd0;
    runSweep(cycles);
    checkOutput("good_latency", cycles, Sweep);
    checkOutput("good_pass", pass, 1);
    checkOutput("good_err_cnt", err_cnt, 0);
    checkOutput("good_ffv", first_fail_vec, 0);
    checkOutput("good_last_vec", dut_in, 15);
    checkOutput("good_busy", busy, 0);
    repeat (4) @(negedge clk);
    checkOutput("good_done_held", done, 1);
    checkOutput("good_pass_held", pass, 1);

    // Stuck-at-0: vectors 3,7,11,12,13,14,15 should fail.
    mode = 2'd1;
    runSweep(cycles);
`ifdef AND_OR_SWEEP_STOP_ON_FAIL_EN
    checkOutput("s0_latency", cycles, 4 * (Settle + 1));
    checkOutput("s0_vec_at_done", dut_in, 3);
    checkOutput("s0_err_cnt", err_cnt, 1);
`else
    checkOutput("s0_latency", cycles, Sweep);
    checkOutput("s0_err_cnt", err_cnt, 7);
`endif
    checkOutput("s0_ffv", first_fail_vec, 4'b0011);
    checkOutput("s0_pass", pass, 0);

    // Stuck-at-1: nine vectors expect 0, the first being vector 0.
    mode = 2'd2;
    runSweep(cycles);
`ifdef AND_OR_SWEEP_STOP_ON_FAIL_EN
    checkOutput("s1_latency", cycles, Settle + 1);
    checkOutput("s1_err_cnt", err_cnt, 1);
`else
    checkOutput("s1_latency", cycles, Sweep);
    checkOutput("s1_err_cnt", err_cnt, 9);
`endif
    checkOutput("s1_ffv", first_fail_vec, 0);
    checkOutput("s1_pass", pass, 0);

    // Abort at vector 5, with a stray start pulse earlier in the sweep.
    mode = 2'd0;
    pulseStart();
    repeat (7) @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    checkOutput("ab_ignored_start_vec", dut_in, 2);
    checkOutput("ab_ignored_start_busy", busy, 1);
    checkOutput("ab_midsweep_pass", pass, 0);
    repeat (7) @(negedge clk);
    checkOutput("ab_vec_before", dut_in, 5);
    checkOutput("ab_busy_before", busy, 1);
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    checkOutput("ab_busy", busy, 0);
    checkOutput("ab_done", done, 0);
    checkOutput("ab_dut_in", dut_in, 0);
    checkOutput("ab_err_cnt", err_cnt, 0);
    repeat (3) @(negedge clk);
    checkOutput("ab_stays_idle_busy", busy, 0);
    checkOutput("ab_stays_idle_vec", dut_in, 0);

    // Reset during SETTLE of vector 9 after a failing sweep left err_cnt non-zero.
    mode = 2'd1;
    pulseStart();
    repeat (27) @(negedge clk);
    checkOutput("rs_vec_before", dut_in, 9);
`ifndef AND_OR_SWEEP_STOP_ON_FAIL_EN
    checkOutput("rs_err_before", err_cnt, 2);
`endif
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rs_busy", busy, 0);
    checkOutput("rs_done", done, 0);
    checkOutput("rs_pass", pass, 0);
    checkOutput("rs_dut_in", dut_in, 0);
    checkOutput("rs_err_cnt", err_cnt, 0);
    checkOutput("rs_ffv", first_fail_vec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rs_no_resume_busy", busy, 0);
    checkOutput("rs_no_resume_vec", dut_in, 0);
    mode = 2'd0;
    runSweep(cycles);
    checkOutput("rs_clean_latency", cycles, Sweep);
    checkOutput("rs_clean_pass", pass, 1);
    checkOutput("rs_clean_err_cnt", err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/and_or_sweep_ctrl.md
AND_OR_SWEEP_CTRL -- requirements
Module: and_or_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the number of cycles each vector is held before sampling (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock (rising edge).
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, sweep request, sampled in IDLE or DONE.
REQ-005 SHALL have port abort, input, 1, synchronous sweep cancel.
REQ-006 SHALL have port dut_in, output, 4, the vector driven to the AND_OR datapath.
REQ-007 SHALL have port dut_out, input, 1, the AND_OR datapath result.
REQ-008 SHALL have port busy, output, 1, high while a sweep is in progress (SETTLE or CHECK).
REQ-009 SHALL have port done, output, 1, high in DONE and held until the next start or reset.
REQ-010 SHALL have port pass, output, 1, high in DONE when err_cnt equals 0.
REQ-011 SHALL have port err_cnt, output, 5, the mismatch count (0..16).
REQ-012 SHALL have port first_fail_vec, output, 4, the first mismatching vector (0 if there was none).

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, CHECK, DONE.
REQ-014 SHALL, on start high in IDLE or DONE, clear err_cnt, first_fail_vec and the fail flag, set dut_in=0, load the settle counter, and enter SETTLE on the next edge.
REQ-015 SHALL stay exactly SETTLE_CYCLES cycles in SETTLE, then spend 1 cycle in CHECK, so each vector occupies SETTLE_CYCLES+1 cycles.
REQ-016 SHALL, in CHECK, compare dut_out against expected = (dut_in[3]&dut_in[2]) | (dut_in[1]&dut_in[0]).
REQ-017 SHALL, on mismatch, increment err_cnt (saturating at 16) and, if this is the first mismatch, capture dut_in into first_fail_vec.
REQ-018 SHALL, leaving CHECK, go to DONE if dut_in==15; otherwise increment dut_in and return to SETTLE.
REQ-019 SHALL hold dut_in stable throughout SETTLE and CHECK of a vector, changing it only on the CHECK->SETTLE edge.
REQ-020 SHALL assert done exactly 16*(SETTLE_CYCLES+1) cycles after the start-accept edge for a full sweep.
REQ-021 SHALL ignore start while busy.
REQ-022 SHALL give abort priority over start when both are asserted in the same cycle.
REQ-023 SHALL, on abort while busy, enter IDLE on the next edge with done=0, dut_in=0, and err_cnt/first_fail_vec retained.
REQ-024 SHALL drive pass=0 whenever done=0.

Reset
REQ-025 SHALL, on rst_n low, immediately force state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vec=0, settle counter=0, independent of clk.
REQ-026 SHALL discard a sweep interrupted by reset mid-operation and not resume it after rst_n deasserts.
REQ-027 SHALL stay in IDLE after rst_n deasserts until start is seen.

Configuration
REQ-028 SHALL, when AND_OR_SWEEP_STOP_ON_FAIL_EN is defined, go from CHECK straight to DONE on the first mismatch (err_cnt=1, pass=0).
REQ-029 SHALL, when AND_OR_SWEEP_STOP_ON_FAIL_EN is undefined, always sweep all 16 vectors regardless of mismatches.

Verification
REQ-030 SHALL cover: correct AND_OR model, SETTLE_CYCLES=2, start pulse -> done 48 cycles after accept, pass=1, err_cnt=0, first_fail_vec=0.
REQ-031 SHALL cover: dut_out stuck at 0, macro undefined -> err_cnt=7, first_fail_vec=4'b0011, pass=0.
REQ-032 SHALL cover: dut_out stuck at 1, macro undefined -> err_cnt=9, first_fail_vec=4'b0000.
REQ-033 SHALL cover: dut_out stuck at 0, AND_OR_SWEEP_STOP_ON_FAIL_EN defined -> done while dut_in=3, err_cnt=1, first_fail_vec=4'b0011.
REQ-034 SHALL cover: abort asserted while dut_in=5 -> IDLE next edge, busy=0, done=0, dut_in=0; a second start pulsed during the first sweep has no effect on it.
REQ-035 SHALL cover: rst_n pulsed low mid-SETTLE at dut_in=9 -> all outputs 0 at once, and a subsequent start gives a clean 48-cycle sweep.
